// File: rtl/truth_table_sweeper.sv
// Truth-table sweeper: drives {a,b,c} through rows 0..7, samples d after a settle
// delay, and compares the observed table against a latched expected minterm mask.
module truth_table_sweeper #(
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] expected,
    input  logic       d,
    output logic       a,
    output logic       b,
    output logic       c,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [7:0] captured,
    output logic [7:0] mismatch,
    output logic [2:0] first_fail
);

    localparam int unsigned CNT_W = 8;
    localparam int unsigned ROW_W = 3;
    localparam int unsigned TT_W  = 8;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(TT_W - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        SAMPLE = 2'd2,
        FINISH = 2'd3
    } state_t;

    state_t            state, state_d;
    logic [ROW_W-1:0]  row, row_d;
    logic [CNT_W-1:0]  cnt, cnt_d;
    logic [TT_W-1:0]   exp_q, exp_d;
    logic [TT_W-1:0]   cap_d, mis_d;
    logic              pass_d;
    logic [ROW_W-1:0]  ff_d;
    logic [ROW_W-1:0]  abc_d;
    logic              busy_d, done_d;

    // Index of the lowest set bit; 0 when no bit is set.
    function automatic logic [ROW_W-1:0] lowest_set(input logic [TT_W-1:0] v);
        logic [ROW_W-1:0] idx;
        logic             found;
        idx   = '0;
        found = 1'b0;
        for (int i = 0; i < int'(TT_W); i++) begin
            if (v[i] && !found) begin
                idx   = ROW_W'(i);
                found = 1'b1;
            end
        end
        return idx;
    endfunction

    // Registers: state, sweep bookkeeping and all outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            row        <= '0;
            cnt        <= '0;
            exp_q      <= '0;
            captured   <= '0;
            mismatch   <= '0;
            pass       <= 1'b0;
            first_fail <= '0;
            {a, b, c}  <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_d;
            row        <= row_d;
            cnt        <= cnt_d;
            exp_q      <= exp_d;
            captured   <= cap_d;
            mismatch   <= mis_d;
            pass       <= pass_d;
            first_fail <= ff_d;
            {a, b, c}  <= abc_d;
            busy       <= busy_d;
            done       <= done_d;
        end
    end

    // Next-state and next-output logic; results are finalised on the last sample edge.
    always_comb begin
        state_d = state;
        row_d   = row;
        cnt_d   = cnt;
        exp_d   = exp_q;
        cap_d   = captured;
        mis_d   = mismatch;
        pass_d  = pass;
        ff_d    = first_fail;

        case (state)
            IDLE: begin
                if (start) begin
                    state_d = DRIVE;
                    exp_d   = expected;
                    cap_d   = '0;
                    mis_d   = '0;
                    pass_d  = 1'b0;
                    ff_d    = '0;
                    row_d   = '0;
                    cnt_d   = '0;
                end
            end
            DRIVE: begin
                cnt_d = cnt + CNT_W'(1);
                if (cnt == CNT_LAST) begin
                    state_d = SAMPLE;
                end
            end
            SAMPLE: begin
                cap_d[row] = d;
                if (row == ROW_LAST) begin
                    state_d = FINISH;
                    mis_d   = cap_d ^ exp_q;
                    pass_d  = (mis_d == '0);
                    ff_d    = lowest_set(mis_d);
                end else begin
                    state_d = DRIVE;
                    row_d   = row + ROW_W'(1);
                    cnt_d   = '0;
                end
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        abc_d  = ((state_d == DRIVE) || (state_d == SAMPLE)) ? row_d : '0;
        busy_d = (state_d != IDLE);
        done_d = (state_d == FINISH);
    end

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Bench for truth_table_sweeper: two instances (settle 1 and 3) driven in parallel,
// a timing model checked every cycle and a result scoreboard popped on done.
module tb_truth_table_sweeper;

    typedef struct packed {
        logic [7:0] cap;
        logic [7:0] mis;
        logic       pass;
        logic [2:0] ff;
    } res_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [7:0] expected = 8'h00;
    logic [7:0] func = 8'h00;
    int         total = 0;
    int         bad = 0;

    always #5 clk = ~clk;

    task automatic check(input string name, input int unsigned act, input int unsigned req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    // Expected sweep result: the block under test's table is exactly what gets captured.
    function automatic res_t ref_result(input logic [7:0] exp_tt, input logic [7:0] obs);
        res_t r;
        bit   found;
        r.cap  = obs;
        r.mis  = obs ^ exp_tt;
        r.pass = (r.mis == 8'h00);
        r.ff   = 3'd0;
        found  = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (r.mis[i] && !found) begin
                r.ff  = 3'(i);
                found = 1'b1;
            end
        end
        return r;
    endfunction

    for (genvar u = 0; u < 2; u++) begin : g_unit
        localparam int unsigned S   = (u == 0) ? 1 : 3;
        localparam int          LAT = 8 * (int'(S) + 1);

        logic       a, b, c, d, busy, done, pass;
        logic [7:0] captured, mismatch;
        logic [2:0] first_fail;

        truth_table_sweeper #(.SETTLE_CYCLES(S)) u_dut (
            .clk        (clk),
            .rst        (rst),
            .start      (start),
            .expected   (expected),
            .d          (d),
            .a          (a),
            .b          (b),
            .c          (c),
            .busy       (busy),
            .done       (done),
            .pass       (pass),
            .captured   (captured),
            .mismatch   (mismatch),
            .first_fail (first_fail)
        );

        // Block under test: a lookup of the current function table.
        assign d = func[{a, b, c}];

        res_t q[$];
        res_t cur;
        res_t held = '0;
        bit   active = 1'b0;
        bit   armed = 1'b0;
        int   k = 0;

        // Model: k counts edges since the accepting edge; a sweep spans LAT+1 busy cycles.
        always @(posedge clk) begin
            if (rst) begin
                active = 1'b0;
                armed  = 1'b1;
                held   = '0;
                q.delete();
            end else if (active) begin
                k++;
                if (k == LAT) held = cur;
                if (k > LAT) active = 1'b0;
            end else if (start) begin
                active = 1'b1;
                k      = 0;
                cur    = ref_result(expected, func);
                q.push_back(cur);
            end
        end

        // Cycle checker: drive pattern, busy, done timing, and held results while idle.
        always @(negedge clk) begin : chk
            int unsigned row_e;
            bit          busy_e, done_e;
            if (armed) begin
                busy_e = active;
                done_e = active && (k == LAT);
                row_e  = (active && k < LAT) ? int'(k / (int'(S) + 1)) : 0;
                check($sformatf("u%0d busy", u), busy, busy_e);
                check($sformatf("u%0d done", u), done, done_e);
                check($sformatf("u%0d abc", u), {a, b, c}, row_e);
                if (!active) begin
                    check($sformatf("u%0d held", u), {captured, mismatch, pass, first_fail}, held);
                end
            end
        end

        // Scoreboard monitor: one expected result per done pulse.
        always @(negedge clk) begin : mon
            res_t want;
            if (done) begin
                if (q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL u%0d unexpected_done: actual=1 required=0 at %0t", u, $time);
                end else begin
                    want = q.pop_front();
                    check($sformatf("u%0d captured", u), captured, want.cap);
                    check($sformatf("u%0d mismatch", u), mismatch, want.mis);
                    check($sformatf("u%0d pass", u), pass, want.pass);
                    check($sformatf("u%0d first_fail", u), first_fail, want.ff);
                end
            end
        end
    end

    task automatic wait_idle();
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            if (!g_unit[0].active && !g_unit[1].active) break;
        end
    endtask

    task automatic run_sweep(input logic [7:0] e);
        @(negedge clk);
        expected = e;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_idle();
    endtask

    logic [7:0] plan_tt;
    logic [7:0] e;

    initial begin
        for (int i = 0; i < 8; i++) begin
            plan_tt[i] = (!i[2] && !i[1]) || !i[0];
        end
        repeat (3) @(negedge clk);
        rst  = 1'b0;
        func = plan_tt;

        run_sweep(8'h57);
        run_sweep(8'h55);
        run_sweep(8'hD7);

        // Second start during the sweep must be ignored.
        func = 8'hFF;
        @(negedge clk);
        expected = 8'hFF;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_idle();

        // Reset mid-sweep abandons it; the next sweep is complete.
        func = plan_tt;
        @(negedge clk);
        expected = 8'h57;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        run_sweep(8'h57);

        // Back-to-back sweeps with expected changed after the first is latched.
        @(negedge clk);
        expected = 8'h57;
        start    = 1'b1;
        repeat (3) @(negedge clk);
        expected = 8'h00;
        repeat (40) @(negedge clk);
        start = 1'b0;
        wait_idle();

        // Randomised sweeps with occasional expected churn and resets.
        for (int n = 0; n < 24; n++) begin
            func = 8'($urandom);
            case ($urandom_range(0, 2))
                0:       e = func;
                1:       e = func ^ 8'(1 << $urandom_range(0, 7));
                default: e = 8'($urandom);
            endcase
            @(negedge clk);
            expected = e;
            start    = 1'b1;
            repeat ($urandom_range(1, 3)) @(negedge clk);
            start = 1'b0;
            repeat ($urandom_range(0, 20)) @(negedge clk);
            expected = 8'($urandom);
            if ($urandom_range(0, 5) == 0) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
            end
            wait_idle();
        end

        repeat (2) @(negedge clk);
        check("u0 pending", g_unit[0].q.size(), 0);
        check("u1 pending", g_unit[1].q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/truth_table_sweeper.md
Name: truth_table_sweeper

Overview:
- Driver/checker side of a 3-input combinational function block (inputs a, b, c; output d).
- Steps {a,b,c} through all 8 combinations (000 to 111) on a start pulse and samples d after a settle delay.
- Assembles the observed 8-entry truth table and compares it with an expected minterm mask.
- Reports pass/fail, per-row mismatches and the first failing row; used for on-board self-test of lab logic functions.

Parameters:
SETTLE_CYCLES, 1, cycles each input combination is driven before d is sampled; legal range 1..255 (8-bit counter).

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous active-high reset
start  input  1  begin sweep; sampled only in IDLE
expected  input  8  expected truth table, bit i = d for {a,b,c}=i; latched on accepted start
d  input  1  function output from block under test
a  output  1  function input, MSB of row index
b  output  1  function input, middle bit of row index
c  output  1  function input, LSB of row index
busy  output  1  high from the cycle after start is accepted until FINISH ends
done  output  1  one-cycle pulse, results valid
pass  output  1  captured == latched expected; valid from done, held until next accepted start
captured  output  8  observed truth table, bit i = sampled d for row i
mismatch  output  8  captured XOR latched expected
first_fail  output  3  lowest set index of mismatch; 0 when pass=1

Behaviour:
- Reset (synchronous, rst=1 at a rising edge):
  - State goes to IDLE.
  - a, b, c, busy, done and pass go to 0.
  - captured, mismatch, first_fail, row index, settle counter and latched expected clear to 0.
  - Reset has priority over every other event, including mid-sweep; the sweep is abandoned with no done pulse.
- States: IDLE, DRIVE, SAMPLE, FINISH.
- IDLE:
  - a=b=c=0, busy=0.
  - start=1 at an edge: latch expected, clear captured, mismatch, pass and first_fail, set row=0 and cnt=0, go to DRIVE.
- DRIVE:
  - {a,b,c}=row, registered outputs, stable for the whole state. busy=1.
  - cnt increments each edge. When cnt==SETTLE_CYCLES-1, go to SAMPLE, so DRIVE lasts exactly SETTLE_CYCLES cycles.
- SAMPLE:
  - {a,b,c} still = row. At the edge, captured[row] <= d.
  - If row==7, go to FINISH. Otherwise row <= row+1, cnt <= 0, go to DRIVE.
  - Row does not wrap; exactly 8 samples per sweep.
- FINISH:
  - a=b=c=0. done=1 for this single cycle.
  - pass, mismatch and first_fail are valid in this same cycle. They are computed combinationally from the final captured value, or registered on the last SAMPLE edge.
  - Next edge goes to IDLE. Results then hold until the next accepted start or reset.
- Latency:
  - done is high in the cycle following the 8*(SETTLE_CYCLES+1)th rising edge after the start-sampling edge.
  - Example: SETTLE_CYCLES=1 gives done 16 edges after start.
- start:
  - Ignored in DRIVE, SAMPLE and FINISH; it is not queued.
  - start held high continuously re-triggers a new sweep from IDLE, one IDLE cycle between sweeps.
- expected:
  - Changes after latching have no effect on the sweep in progress.
- d:
  - Treated as synchronous to clk. Asynchronous sources must be synchronized externally.

Test Plan:
- d driven by (~a&~b)|~c, expected=8'h57, SETTLE_CYCLES=1, pulse start -> captured=8'h57, mismatch=8'h00, pass=1, first_fail=0, done one cycle exactly 16 edges after the start edge.
- Same DUT, expected=8'h55 -> pass=0, mismatch=8'h02, first_fail=1; rerun with expected=8'hD7 -> mismatch=8'h80, first_fail=7.
- Monitor {a,b,c} with SETTLE_CYCLES=3 -> values 0,1,...,7 in order, each held 4 cycles (3 DRIVE + 1 SAMPLE), then 0; done 32 edges after start; busy high for the 32 cycles before done and during done.
- start pulsed again at edge 5 of a sweep -> no restart, row sequence unaffected, single done pulse; d tied to 1 gives captured=8'hFF.
- rst asserted at edge 6 of a sweep -> next cycle a=b=c=0, busy=0, captured=0, no done pulse; subsequent start yields a full correct 8-row sweep.
- Back-to-back sweeps, expected changed mid-sweep from 8'h57 to 8'h00 -> first result still pass=1; second sweep with 8'h00 gives pass=0, mismatch=8'h57, first_fail=0.
